// File: rtl/cn_min_pkg.sv
// Shared constants and helpers for the check-node min-tree reducer.
package cn_min_pkg;

  // All-ones magnitude for a W-bit sign-magnitude message.
  function automatic int mag_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic bit n_is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  // Width of one packed node record {min1, min2, idx, sign}.
  function automatic int node_w(input int w, input int n);
    return 2 * (w - 1) + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/cn_min_tree_pipelined_if.sv
// Beat input / reduced result bundle of the check-node min-tree reducer.
interface cn_min_tree_pipelined_if #(
  parameter int W = 6,
  parameter int N = 32
);
  localparam int IW = $clog2(N);

  logic             en;
  logic             in_valid;
  logic [N*W-1:0]   x;
  logic [N-1:0]     mask;
  logic             out_valid;
  logic [W-2:0]     min1;
  logic [W-2:0]     min2;
  logic [IW-1:0]    idx;
  logic             sign_prod;
  logic [N-1:0]     out_signs;

  modport master (
    output en, in_valid, x, mask,
    input  out_valid, min1, min2, idx, sign_prod, out_signs
  );

  modport slave (
    input  en, in_valid, x, mask,
    output out_valid, min1, min2, idx, sign_prod, out_signs
  );
endinterface

// File: rtl/cn_min_merge.sv
// Combinational merge of two min-sum nodes; A covers the lower lanes, B the upper.
module cn_min_merge #(
  parameter int MW  = 5,
  parameter int IW  = 5,
  parameter int LVL = 0
) (
  input  logic [MW-1:0] i_a_min1,
  input  logic [MW-1:0] i_a_min2,
  input  logic [IW-1:0] i_a_idx,
  input  logic          i_a_sign,
  input  logic [MW-1:0] i_b_min1,
  input  logic [MW-1:0] i_b_min2,
  input  logic [IW-1:0] i_b_idx,
  input  logic          i_b_sign,
  output logic [MW-1:0] o_min1,
  output logic [MW-1:0] o_min2,
  output logic [IW-1:0] o_idx,
  output logic          o_sign
);
  logic          w_take_b;
  logic [MW-1:0] w_lo_when_b;
  logic [MW-1:0] w_lo_when_a;
  logic [IW-1:0] w_lvl_bit;

  // Strict compare so equal minima keep the lower-lane node.
  assign w_take_b    = (i_a_min1 > i_b_min1);
  assign w_lo_when_b = (i_a_min1 < i_b_min2) ? i_a_min1 : i_b_min2;
  assign w_lo_when_a = (i_a_min2 < i_b_min1) ? i_a_min2 : i_b_min1;
  assign w_lvl_bit   = w_take_b ? (IW'(1) << LVL) : '0;

  assign o_min1 = w_take_b ? i_b_min1 : i_a_min1;
  assign o_min2 = w_take_b ? w_lo_when_b : w_lo_when_a;
  assign o_idx  = (w_take_b ? i_b_idx : i_a_idx) | w_lvl_bit;
  assign o_sign = i_a_sign ^ i_b_sign;
endmodule

// File: rtl/cn_min_tree_pipelined.sv
// Pipelined N-lane min1/min2/index/sign reducer: one merge level per register stage.
module cn_min_tree_pipelined
  import cn_min_pkg::*;
#(
  parameter int W = 6,
  parameter int N = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  cn_min_tree_pipelined_if.slave   bus
);
  localparam int IW    = $clog2(N);
  localparam int M     = W - 1;
  localparam int NODES = N - 1;
  localparam logic [M-1:0] MAG_MAX = M'(mag_max(W));

  if (!n_is_pow2(N)) begin : g_bad_n
    $error("cn_min_tree_pipelined: N must be a power of two >= 2");
  end

  logic [M-1:0]  w_lmag [N];
  logic [N-1:0]  w_lsgn;

  // Nodes are stored level by level: level l starts at N - (N >> l).
  logic [M-1:0]  w_min1 [NODES];
  logic [M-1:0]  w_min2 [NODES];
  logic [IW-1:0] w_idx  [NODES];
  logic          w_sgn  [NODES];
  logic [M-1:0]  r_min1 [NODES];
  logic [M-1:0]  r_min2 [NODES];
  logic [IW-1:0] r_idx  [NODES];
  logic          r_sgn  [NODES];
  logic          r_vld  [IW];
  logic [N-1:0]  r_signs [IW];

  // Lane conditioning: masked lanes look like the weakest possible message.
  always_comb begin
    w_lsgn = '0;
    for (int i = 0; i < N; i++) begin
      w_lmag[i] = bus.mask[i] ? bus.x[i*W +: M] : MAG_MAX;
      w_lsgn[i] = bus.mask[i] & bus.x[i*W + W - 1];
    end
  end

  for (genvar l = 0; l < IW; l++) begin : g_lvl
    localparam int OFF = N - (N >> l);
    localparam int CNT = N >> (l + 1);
    for (genvar k = 0; k < CNT; k++) begin : g_node
      if (l == 0) begin : g_leaf
        cn_min_merge #(.MW(M), .IW(IW), .LVL(0)) u_merge (
          .i_a_min1 (w_lmag[2*k]),
          .i_a_min2 (MAG_MAX),
          .i_a_idx  ({IW{1'b0}}),
          .i_a_sign (w_lsgn[2*k]),
          .i_b_min1 (w_lmag[2*k+1]),
          .i_b_min2 (MAG_MAX),
          .i_b_idx  ({IW{1'b0}}),
          .i_b_sign (w_lsgn[2*k+1]),
          .o_min1   (w_min1[OFF+k]),
          .o_min2   (w_min2[OFF+k]),
          .o_idx    (w_idx[OFF+k]),
          .o_sign   (w_sgn[OFF+k])
        );
      end else begin : g_inner
        localparam int COFF = N - (N >> (l - 1));
        cn_min_merge #(.MW(M), .IW(IW), .LVL(l)) u_merge (
          .i_a_min1 (r_min1[COFF+2*k]),
          .i_a_min2 (r_min2[COFF+2*k]),
          .i_a_idx  (r_idx[COFF+2*k]),
          .i_a_sign (r_sgn[COFF+2*k]),
          .i_b_min1 (r_min1[COFF+2*k+1]),
          .i_b_min2 (r_min2[COFF+2*k+1]),
          .i_b_idx  (r_idx[COFF+2*k+1]),
          .i_b_sign (r_sgn[COFF+2*k+1]),
          .o_min1   (w_min1[OFF+k]),
          .o_min2   (w_min2[OFF+k]),
          .o_idx    (w_idx[OFF+k]),
          .o_sign   (w_sgn[OFF+k])
        );
      end
    end
  end

  // Stage registers, valid bits and sign delay line all advance together on en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NODES; i++) begin
        r_min1[i] <= '0;
        r_min2[i] <= '0;
        r_idx[i]  <= '0;
        r_sgn[i]  <= 1'b0;
      end
      for (int d = 0; d < IW; d++) begin
        r_vld[d]   <= 1'b0;
        r_signs[d] <= '0;
      end
    end else if (bus.en) begin
      for (int i = 0; i < NODES; i++) begin
        r_min1[i] <= w_min1[i];
        r_min2[i] <= w_min2[i];
        r_idx[i]  <= w_idx[i];
        r_sgn[i]  <= w_sgn[i];
      end
      r_vld[0]   <= bus.in_valid;
      r_signs[0] <= w_lsgn;
      for (int d = 1; d < IW; d++) begin
        r_vld[d]   <= r_vld[d-1];
        r_signs[d] <= r_signs[d-1];
      end
    end
  end

  assign bus.out_valid = r_vld[IW-1];
  assign bus.min1      = r_min1[NODES-1];
  assign bus.min2      = r_min2[NODES-1];
  assign bus.idx       = r_idx[NODES-1];
  assign bus.sign_prod = r_sgn[NODES-1];
  assign bus.out_signs = r_signs[IW-1];
endmodule

// File: tb/tb_cn_min_tree_pipelined.sv
// Directed and scoreboarded bench for cn_min_tree_pipelined at N=32/W=6, N=2/W=4, N=64/W=8.
module tb_cn_min_tree_pipelined;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cn_min_tree_pipelined_if #(.W(6), .N(32)) a_if ();
  cn_min_tree_pipelined_if #(.W(4), .N(2))  b_if ();
  cn_min_tree_pipelined_if #(.W(8), .N(64)) c_if ();

  cn_min_tree_pipelined #(.W(6), .N(32)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  cn_min_tree_pipelined #(.W(4), .N(2))  u_b (.clk(clk), .rst(rst), .bus(b_if));
  cn_min_tree_pipelined #(.W(8), .N(64)) u_c (.clk(clk), .rst(rst), .bus(c_if));

  typedef struct packed {
    logic [4:0]  m1;
    logic [4:0]  m2;
    logic [4:0]  id;
    logic        sp;
    logic [31:0] sg;
  } ea_t;

  typedef struct packed {
    logic [6:0]  m1;
    logic [6:0]  m2;
    logic [5:0]  id;
    logic        sp;
    logic [63:0] sg;
  } ec_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  ea_t qa[$];
  ec_t qc[$];
  ea_t exp_r[8];
  int  gm[64];
  bit  gs[64];
  bit  gk[64];
  int  bm[8][32];
  bit  bs[8][32];
  logic a_en_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: linear scan, first lane wins ties, min2 is the best of the rest.
  function automatic void model(input int n, input int mx, input int m[64], input bit s[64],
                                input bit k[64], output int m1, output int m2, output int id,
                                output bit sp, output logic [63:0] sg);
    int v;
    m1 = mx; m2 = mx; id = 0; sp = 1'b0; sg = '0;
    for (int i = 0; i < n; i++) begin
      v = k[i] ? m[i] : mx;
      if (v < m1) begin m1 = v; id = i; end
      if (k[i]) begin sp ^= s[i]; sg[i] = s[i]; end
    end
    for (int i = 0; i < n; i++) begin
      v = k[i] ? m[i] : mx;
      if (i != id && v < m2) m2 = v;
    end
  endfunction

  task automatic set_all(input int mag, input bit sg, input bit k);
    for (int i = 0; i < 64; i++) begin gm[i] = mag; gs[i] = sg; gk[i] = k; end
  endtask

  task automatic drive_a(input bit v);
    logic [191:0] xv;
    logic [31:0]  mk;
    for (int i = 0; i < 32; i++) begin
      xv[i*6 +: 6] = {gs[i], 5'(gm[i])};
      mk[i] = gk[i];
    end
    a_if.x = xv; a_if.mask = mk; a_if.in_valid = v;
  endtask

  task automatic drive_c(input bit v);
    logic [511:0] xv;
    logic [63:0]  mk;
    for (int i = 0; i < 64; i++) begin
      xv[i*8 +: 8] = {gs[i], 7'(gm[i])};
      mk[i] = gk[i];
    end
    c_if.x = xv; c_if.mask = mk; c_if.in_valid = v;
  endtask

  task automatic push_a(input int m1, input int m2, input int id, input bit sp, input logic [31:0] sg);
    ea_t e;
    e.m1 = 5'(m1); e.m2 = 5'(m2); e.id = 5'(id); e.sp = sp; e.sg = sg;
    qa.push_back(e);
  endtask

  function automatic ea_t model_a();
    int m1, m2, id; bit sp; logic [63:0] sg; ea_t e;
    model(32, 31, gm, gs, gk, m1, m2, id, sp, sg);
    e.m1 = 5'(m1); e.m2 = 5'(m2); e.id = 5'(id); e.sp = sp; e.sg = sg[31:0];
    return e;
  endfunction

  task automatic push_c_model();
    int m1, m2, id; bit sp; logic [63:0] sg; ec_t e;
    model(64, 127, gm, gs, gk, m1, m2, id, sp, sg);
    e.m1 = 7'(m1); e.m2 = 7'(m2); e.id = 6'(id); e.sp = sp; e.sg = sg;
    qc.push_back(e);
  endtask

  always @(posedge clk) a_en_last <= a_if.en;

  // Result monitors: every result slot produced by an enabled edge is scored in order.
  always @(negedge clk) begin
    if (rst && a_if.out_valid && a_en_last) begin
      if (qa.size() == 0) chk("a_extra_valid", 1, 0);
      else begin
        ea_t e;
        e = qa.pop_front();
        chk("a_min1", a_if.min1, e.m1);
        chk("a_min2", a_if.min2, e.m2);
        chk("a_idx", a_if.idx, e.id);
        chk("a_sign_prod", a_if.sign_prod, e.sp);
        chk("a_out_signs", a_if.out_signs, e.sg);
      end
    end
    if (rst && c_if.out_valid) begin
      if (qc.size() == 0) chk("c_extra_valid", 1, 0);
      else begin
        ec_t e;
        e = qc.pop_front();
        chk("c_min1", c_if.min1, e.m1);
        chk("c_min2", c_if.min2, e.m2);
        chk("c_idx", c_if.idx, e.id);
        chk("c_sign_prod", c_if.sign_prod, e.sp);
        chk("c_out_signs", c_if.out_signs, e.sg);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    a_if.en = 1'b1; a_if.in_valid = 1'b0; a_if.x = '0; a_if.mask = '0;
    b_if.en = 1'b1; b_if.in_valid = 1'b0; b_if.x = '0; b_if.mask = '0;
    c_if.en = 1'b1; c_if.in_valid = 1'b0; c_if.x = '0; c_if.mask = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", a_if.out_valid, 0);
    chk("rst_min1", a_if.min1, 0);
    chk("rst_out_signs", a_if.out_signs, 0);
    rst = 1'b1;

    // Basic reduction with latency probe
    @(negedge clk);
    set_all(31, 1'b0, 1'b1);
    gm[7] = 3; gm[20] = 5; gs[0] = 1'b1; gs[7] = 1'b1;
    push_a(3, 5, 7, 1'b0, 32'h0000_0081);
    drive_a(1'b1);
    @(negedge clk);
    drive_a(1'b0);
    repeat (3) @(negedge clk);
    chk("t1_valid_at_4", a_if.out_valid, 0);
    @(negedge clk);
    chk("t1_valid_at_5", a_if.out_valid, 1);

    // Tie-break, masking, all-masked, back to back
    @(negedge clk);
    set_all(9, 1'b0, 1'b1);
    gm[4] = 2; gm[12] = 2; gm[30] = 2;
    push_a(2, 2, 4, 1'b0, 32'h0);
    drive_a(1'b1);
    @(negedge clk);
    set_all(15, 1'b0, 1'b1);
    gm[3] = 0; gk[3] = 1'b0; gs[3] = 1'b1; gm[10] = 6; gs[10] = 1'b1;
    push_a(6, 15, 10, 1'b1, 32'h0000_0400);
    drive_a(1'b1);
    @(negedge clk);
    set_all(0, 1'b1, 1'b0);
    push_a(31, 31, 0, 1'b0, 32'h0);
    drive_a(1'b1);
    @(negedge clk);
    drive_a(1'b0);
    repeat (8) @(negedge clk);

    // Streaming with a 3-cycle stall after six beats
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 32; i++) begin
        bm[b][i] = int'($urandom_range(0, 31));
        bs[b][i] = 1'($urandom_range(0, 1));
        gm[i] = bm[b][i]; gs[i] = bs[b][i]; gk[i] = 1'b1;
      end
      exp_r[b] = model_a();
      qa.push_back(exp_r[b]);
    end
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      if (b == 6) begin
        a_if.en = 1'b0;
        set_all(0, 1'b1, 1'b1);
        drive_a(1'b1);
        repeat (3) begin
          @(negedge clk);
          chk("t4_hold_valid", a_if.out_valid, 1);
          chk("t4_hold_min1", a_if.min1, exp_r[1].m1);
          chk("t4_hold_min2", a_if.min2, exp_r[1].m2);
          chk("t4_hold_idx", a_if.idx, exp_r[1].id);
          chk("t4_hold_signs", a_if.out_signs, exp_r[1].sg);
        end
        a_if.en = 1'b1;
      end
      for (int i = 0; i < 32; i++) begin gm[i] = bm[b][i]; gs[i] = bs[b][i]; gk[i] = 1'b1; end
      drive_a(1'b1);
    end
    @(negedge clk);
    drive_a(1'b0);
    repeat (8) @(negedge clk);

    // Asynchronous reset with three beats in flight
    set_all(20, 1'b0, 1'b1);
    gm[0] = 1; gs[0] = 1'b1;
    push_a(1, 20, 0, 1'b1, 32'h0000_0001);
    drive_a(1'b1);
    repeat (4) @(negedge clk);
    drive_a(1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_valid", a_if.out_valid, 0);
    chk("t5_rst_min1", a_if.min1, 0);
    chk("t5_rst_min2", a_if.min2, 0);
    chk("t5_rst_idx", a_if.idx, 0);
    chk("t5_rst_sign", a_if.sign_prod, 0);
    chk("t5_rst_signs", a_if.out_signs, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    set_all(20, 1'b0, 1'b1);
    gm[9] = 2; gs[9] = 1'b1;
    push_a(2, 20, 9, 1'b1, 32'h0000_0200);
    drive_a(1'b1);
    @(negedge clk);
    drive_a(1'b0);
    chk("t5_post_valid_1", a_if.out_valid, 0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("t5_post_valid_%0d", c), a_if.out_valid, 0);
    end
    @(negedge clk);
    chk("t5_post_valid_5", a_if.out_valid, 1);

    // N=2, W=4: latency 1
    @(negedge clk);
    b_if.x = {4'b0101, 4'b0101}; b_if.mask = 2'b11; b_if.in_valid = 1'b1;
    chk("b_idle_valid", b_if.out_valid, 0);
    @(negedge clk);
    b_if.x = {4'b0010, 4'b1110};
    chk("b1_valid", b_if.out_valid, 1);
    chk("b1_min1", b_if.min1, 5);
    chk("b1_min2", b_if.min2, 5);
    chk("b1_idx", b_if.idx, 0);
    chk("b1_sign", b_if.sign_prod, 0);
    @(negedge clk);
    b_if.in_valid = 1'b0;
    chk("b2_min1", b_if.min1, 2);
    chk("b2_min2", b_if.min2, 6);
    chk("b2_idx", b_if.idx, 1);
    chk("b2_sign", b_if.sign_prod, 1);
    chk("b2_signs", b_if.out_signs, 2'b01);
    @(negedge clk);
    chk("b_end_valid", b_if.out_valid, 0);

    // N=64, W=8 random beats with sparse masking
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 64; i++) begin
        gm[i] = int'($urandom_range(0, 126));
        gs[i] = 1'($urandom_range(0, 1));
        gk[i] = ($urandom_range(0, 3) != 0);
      end
      push_c_model();
      drive_c(1'b1);
      @(negedge clk);
    end
    drive_c(1'b0);

    for (int i = 0; i < 40 && (qa.size() != 0 || qc.size() != 0); i++) @(negedge clk);
    chk("drain_a", qa.size(), 0);
    chk("drain_c", qc.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cn_min_tree_pipelined.md
# cn_min_tree_pipelined

Parametrised, pipelined check-node magnitude reducer for the min-sum LDPC decoder. Takes N sign-magnitude messages per beat and returns the smallest magnitude (min1), second-smallest (min2), min1 lane index, XOR of all signs, and the lane signs delay-aligned to the result. It generalises the fixed 32-input tree to any power-of-two N, and adds:
- a valid/stall pipeline;
- per-lane masking, for rows of degree < N;
- sign processing.

## Interface
- W, default 6: message width in bits; bit W-1 is the sign, bits W-2:0 are the magnitude.
- N, default 32: number of input lanes; power of two, N ≥ 2.
- IW, derived as $clog2(N): index width; not overridable.
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  pipeline advance enable; 0 freezes every stage.
- in_valid  in  1  qualifies x and mask for the current beat.
- x  in  N*W  lane i occupies x[i*W +: W].
- mask  in  N  1 = lane i participates; 0 = lane i is ignored.
- out_valid  out  1  result valid.
- min1  out  W-1  smallest participating magnitude.
- min2  out  W-1  second-smallest participating magnitude.
- idx  out  IW  lane index of min1.
- sign_prod  out  1  XOR of the signs of participating lanes.
- out_signs  out  N  per-lane signs of the same beat; masked lanes read 0.

## Operation
**Lane conditioning (combinational, before stage 1):**
- Participating lane: magnitude = x[i*W +: W-1], sign = x[i*W+W-1].
- Masked lane: magnitude forced to MAG_MAX (all ones), sign forced to 0.

**Leaf pairs (lanes 2k and 2k+1):**
- min1 = the smaller magnitude; min2 = the larger.
- idx bit 0 = 1 only if lane 2k+1 is strictly smaller. Ties go to the lower lane.
- sign = XOR of the two signs.

**Merge of node A (lower lanes) and node B (upper lanes):**
- take_b = (A.min1 > B.min1), a strict comparison, so ties keep A.
- min1 = take_b ? B.min1 : A.min1.
- min2 = take_b ? min(A.min1, B.min2) : min(A.min2, B.min1).
- idx = {take_b, take_b ? B.idx : A.idx}. Each level prepends one MSB.
- sign = A.sign ^ B.sign.

**Tree and registers:**
- The tree has IW levels. A register follows every level, including the last.
- The final register drives the outputs directly.

**Valid and sign delay:**
- A valid bit travels with each stage.
- out_signs passes through an IW-deep delay line that advances in lockstep with the tree.

**Boundary cases:**
- All lanes masked: min1 = min2 = MAG_MAX, idx = 0, sign_prod = 0, out_signs = 0.
- Exactly one lane participating: min1 = that magnitude, min2 = MAG_MAX, idx = that lane.
- in_valid = 0: data registers still load but outputs are don't-care; out_valid = 0 for that slot.

## Timing
- Latency is IW cycles from a beat accepted with en = 1 to out_valid = 1, counting enabled cycles only. N = 32 gives 5.
- Throughput is one beat per enabled cycle. There is no backpressure output; the consumer stalls the block through en.
- en = 0 holds all stage registers, the valid bits and the sign delay line. Outputs stay stable, and a beat presented during that cycle is not captured.
- rst low clears immediately, without waiting for a clock edge:
  - Cleared: out_valid, min1, min2, idx, sign_prod, out_signs, all internal valid bits, all stage data.
  - In-flight beats are discarded.
  - After rst deasserts, the first out_valid appears IW enabled cycles after the first accepted in_valid.
- Both reset assertion and release are asynchronous to clk. The surrounding design synchronises release.

## Structure
- Package cn_min_pkg:
  - function for MAG_MAX(W);
  - node record typedef {min1, min2, idx, sign}, parametrised by W and N;
  - helper enforcing N as a power of two ≥ 2.
- Sub-module cn_min_merge: the combinational two-node merge, used for leaf pairs and every tree level. The leaf variant takes raw magnitudes with min2 = the other lane.
- The top level generates the IW levels, their registers and the valid/sign delay lines.

## Test plan
Unless noted, N = 32, W = 6 and mask = all ones.

1. **Basic reduction.** Lane magnitudes 31, except lane 7 = 3 and lane 20 = 5. Signs are 1 on lanes 0 and 7, 0 elsewhere. Expect after 5 cycles: min1 = 3, min2 = 5, idx = 7, sign_prod = 0, and out_signs bits 0 and 7 set.
2. **Tie-break.** Lanes 4, 12 and 30 = 2; all others 9. Expect min1 = 2, min2 = 2, idx = 4.
3. **Masking.** Lane 3 = 0 with mask[3] = 0; lane 10 = 6; the rest 15. Expect min1 = 6, min2 = 15, idx = 10. With mask = 0: expect min1 = min2 = 31, idx = 0, sign_prod = 0.
4. **Streaming with stall.** Send 8 back-to-back random beats, hold en = 0 for 3 cycles mid-stream, then resume. Expect results in order, each matching the scoreboard. out_valid and all outputs hold constant during the stall.
5. **Reset mid-stream.** Assert rst while 3 beats are in flight. Expect all outputs 0 within the same cycle. After release, no stale out_valid before a new beat has traversed 5 enabled cycles.
6. **Parameter sweep.** Run N = 2, W = 4: lanes (5, 5) gives min1 = 5, min2 = 5, idx = 0, latency 1. Run N = 64, W = 8 with random vectors against the scoreboard.
